eth_rx_frame_guard: RTL
=======================

Name: eth_rx_frame_guard

Overview:
- AXI-Stream frame guard between one ethernet_mac rx_fifo output and the matching DPE from_eth_N input, all in the sys_clk domain.
- Drops whole frames while the port is disabled.
- Truncates frames longer than MAX_BEATS, forcing tlast and discarding the tail.
- Registers the output (1-cycle latency) and optionally keeps per-port frame statistics for CSR readback.

Parameters:
DATA_W, 64, tdata width in bits; tkeep width is DATA_W/8
MAX_BEATS, 190, maximum beats forwarded per frame (1518 B at 8 B/beat); legal range 2..65535
CNT_W, 32, width of statistics counters

Ports:
clk  input  1  sys_clk; all logic on rising edge
rst  input  1  asynchronous, active-high reset (sys_rst)
enable  input  1  CSR port enable; sampled only at frame start
s_tdata  input  DATA_W  upstream data
s_tkeep  input  DATA_W/8  upstream byte enables
s_tvalid  input  1  upstream valid
s_tready  output  1  upstream ready
s_tlast  input  1  upstream end of frame
m_tdata  output  DATA_W  downstream data (registered)
m_tkeep  output  DATA_W/8  downstream byte enables (registered)
m_tvalid  output  1  downstream valid (registered)
m_tready  input  1  downstream ready
m_tlast  output  1  downstream end of frame (registered)
frames_ok  output  CNT_W  frames forwarded intact
frames_dropped  output  CNT_W  frames dropped because the port was disabled
frames_trunc  output  CNT_W  frames truncated at MAX_BEATS

Behaviour:
- Reset (async, rst=1):
  - m_tvalid=0, m_tdata=0, m_tkeep=0, m_tlast=0.
  - State IDLE, beat counter 0, all statistics counters 0.
- Input beat accepted when s_tvalid & s_tready.
- Output register is single-entry:
  - load_ok = !m_tvalid | m_tready.
  - In IDLE and PASS, s_tready = load_ok.
  - In DROP and DISCARD, s_tready = 1 and the output register is not loaded.
- Latency: an accepted forwarded beat appears on m_* the next cycle. Full throughput while m_tready=1.
- m_* hold stable while m_tvalid & !m_tready.
- m_tvalid clears on m_tready when no new beat is loaded.
- States:
  - IDLE: no frame in progress. On an accepted beat:
    - enable=1, s_tlast=1: forward; frames_ok++; stay IDLE.
    - enable=1, s_tlast=0: forward; beat_cnt=1; go to PASS.
    - enable=0: do not forward; frames_dropped++; go to DROP if s_tlast=0, else stay IDLE.
  - PASS: forward each accepted beat; beat_cnt++.
    - s_tlast=1: frames_ok++; go to IDLE.
    - s_tlast=0 and beat_cnt+1==MAX_BEATS: forward the beat with m_tlast forced to 1; frames_trunc++; go to DISCARD.
  - DROP / DISCARD: consume beats without forwarding; go to IDLE on an accepted s_tlast.
- A frame of exactly MAX_BEATS ending in s_tlast is not truncated and counts as frames_ok.
- enable changes during a frame have no effect until the next IDLE frame start.
- s_tkeep is passed through unmodified, including on a forced-tlast beat.
- beat_cnt width = $clog2(MAX_BEATS+1); it resets to 0 on every return to IDLE.
- Counters saturate at all-ones and never wrap.
- Simultaneous load and drain of the output register: the new beat replaces the old in the same cycle and m_tvalid stays 1.
- Reset mid-frame: the partial frame is abandoned. After release, the first accepted beat is treated as a frame start, even if it is a mid-frame beat upstream.

Optional Feature:
- Macro: ETH_RX_FRAME_GUARD_STATS_EN.
- Defined: the three counters are implemented as described.
- Undefined: frames_ok, frames_dropped and frames_trunc are tied to 0, no counter flops are built, and the ports remain present so top-level wiring is unchanged.
- Datapath and state machine are identical in both builds.

Test Plan:
Bench configuration for all scenarios: DATA_W=64, MAX_BEATS=4.
1. enable=1, m_tready=1, 3-beat frame (data 0x11,0x22,0x33, last tkeep=0x0F) -> same 3 beats out, each 1 cycle later; tlast on 0x33 with tkeep 0x0F; frames_ok=1.
2. enable=0, 5-beat frame, then enable=1 and a 1-beat frame 0xAA -> s_tready=1 throughout; only 0xAA out with tlast; frames_dropped=1, frames_ok=1.
3. enable=1, 7-beat frame 0x01..0x07 -> 0x01..0x04 out with tlast forced on 0x04; 0x05..0x07 consumed, not forwarded; frames_trunc=1. A following 4-beat frame gives frames_ok=1 and no truncation.
4. enable=1, 3-beat frame, m_tready held 0 for 5 cycles after the first output -> m_tvalid=1 and m_tdata=0x11 held stable; s_tready=0 during the stall; frames_ok=1 after drain, no beats lost.
5. enable=1, rst=1 asserted after beat 2 of a 4-beat frame (0x01..0x04), then released; beats 0x03,0x04 continue -> m_tvalid=0 immediately on reset; after release 0x03,0x04 are forwarded as a new frame; counters restart from 0 (frames_ok=1 after 0x04).
6. Stats macro undefined, scenario 3 repeated -> identical m_* sequence; all three counters read 0.

Source files
------------

// File: rtl/eth_rx_frame_guard.sv
// AXI-Stream rx frame guard: drops frames while disabled, truncates at MAX_BEATS, registered output.
// Define ETH_RX_FRAME_GUARD_STATS_EN to build the frames_ok/frames_dropped/frames_trunc counters.
module eth_rx_frame_guard #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned MAX_BEATS = 190,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DATA_W-1:0]     s_tdata,
    input  logic [DATA_W/8-1:0]   s_tkeep,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    output logic [DATA_W-1:0]     m_tdata,
    output logic [DATA_W/8-1:0]   m_tkeep,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic [CNT_W-1:0]      frames_ok,
    output logic [CNT_W-1:0]      frames_dropped,
    output logic [CNT_W-1:0]      frames_trunc
);
    localparam int unsigned KEEP_W = DATA_W / 8;
    localparam int unsigned BCNT_W = $clog2(MAX_BEATS + 1);
    // beat_cnt + 1 == MAX_BEATS, folded into a constant compare
    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(MAX_BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PASS,
        ST_DROP,
        ST_DISCARD
    } state_t;

    state_t              state_q, state_d;
    logic [BCNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [DATA_W-1:0]   m_tdata_q, m_tdata_d;
    logic [KEEP_W-1:0]   m_tkeep_q, m_tkeep_d;
    logic                m_tvalid_q, m_tvalid_d;
    logic                m_tlast_q, m_tlast_d;
    logic                load_ok;
    logic                accept;
    logic                fwd;
    logic                force_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        if (accept) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        if (!s_tlast) begin
                            state_d    = ST_PASS;
                            beat_cnt_d = BCNT_W'(1);
                        end
                    end else if (!s_tlast) begin
                        state_d = ST_DROP;
                    end
                end
                ST_PASS: begin
                    if (s_tlast) begin
                        state_d    = ST_IDLE;
                        beat_cnt_d = '0;
                    end else if (beat_cnt_q == LAST_BEAT) begin
                        state_d    = ST_DISCARD;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (s_tlast) state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        load_ok    = !m_tvalid_q | m_tready;
        s_tready   = 1'b1;
        fwd        = 1'b0;
        force_last = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                s_tready = load_ok;
                fwd      = s_tvalid & load_ok & enable;
            end
            ST_PASS: begin
                s_tready   = load_ok;
                fwd        = s_tvalid & load_ok;
                force_last = fwd & !s_tlast & (beat_cnt_q == LAST_BEAT);
            end
            default: ;
        endcase
        accept = s_tvalid & s_tready;
    end

    always_comb begin
        m_tdata_d  = m_tdata_q;
        m_tkeep_d  = m_tkeep_q;
        m_tlast_d  = m_tlast_q;
        m_tvalid_d = m_tvalid_q;
        if (fwd) begin
            m_tdata_d  = s_tdata;
            m_tkeep_d  = s_tkeep;
            m_tlast_d  = s_tlast | force_last;
            m_tvalid_d = 1'b1;
        end else if (m_tready) begin
            m_tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tdata_q  <= '0;
            m_tkeep_q  <= '0;
            m_tlast_q  <= 1'b0;
            m_tvalid_q <= 1'b0;
        end else begin
            m_tdata_q  <= m_tdata_d;
            m_tkeep_q  <= m_tkeep_d;
            m_tlast_q  <= m_tlast_d;
            m_tvalid_q <= m_tvalid_d;
        end
    end

    assign m_tdata  = m_tdata_q;
    assign m_tkeep  = m_tkeep_q;
    assign m_tlast  = m_tlast_q;
    assign m_tvalid = m_tvalid_q;

`ifdef ETH_RX_FRAME_GUARD_STATS_EN
    logic             ev_ok, ev_drop, ev_trunc;
    logic [CNT_W-1:0] frames_ok_q, frames_ok_d;
    logic [CNT_W-1:0] frames_dropped_q, frames_dropped_d;
    logic [CNT_W-1:0] frames_trunc_q, frames_trunc_d;

    // Counters saturate at all-ones rather than wrapping
    always_comb begin
        ev_ok            = fwd & s_tlast;
        ev_drop          = accept & (state_q == ST_IDLE) & !enable;
        ev_trunc         = force_last;
        frames_ok_d      = frames_ok_q;
        frames_dropped_d = frames_dropped_q;
        frames_trunc_d   = frames_trunc_q;
        if (ev_ok && (frames_ok_q != '1)) frames_ok_d = frames_ok_q + 1'b1;
        if (ev_drop && (frames_dropped_q != '1)) frames_dropped_d = frames_dropped_q + 1'b1;
        if (ev_trunc && (frames_trunc_q != '1)) frames_trunc_d = frames_trunc_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frames_ok_q      <= '0;
            frames_dropped_q <= '0;
            frames_trunc_q   <= '0;
        end else begin
            frames_ok_q      <= frames_ok_d;
            frames_dropped_q <= frames_dropped_d;
            frames_trunc_q   <= frames_trunc_d;
        end
    end

    assign frames_ok      = frames_ok_q;
    assign frames_dropped = frames_dropped_q;
    assign frames_trunc   = frames_trunc_q;
`else
    assign frames_ok      = '0;
    assign frames_dropped = '0;
    assign frames_trunc   = '0;
`endif

endmodule
